ram_bank: RTL and testbench

Parametrised word-addressable RAM bank: the generalised successor to the fixed 8×16 RAM. It adds configurable width and depth, an asynchronous active-low reset, and a hardware clear sweep that zeroes every word after reset. A `ready` flag marks when the sweep is done. It is the building block for the larger RAM64/RAM512/RAM4K/RAM16K tiers and the data memory, with the same `in`/`load`/`address`/`out` access semantics as the smaller RAMs.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_clear_fsm.sv | 61 ++++++
 rtl/ram_bank.sv | 94 +++++++++
 tb/tb_ram_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and default sizes for the RAM bank family.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int RAM_WIDTH_DEF  = 16;
  localparam int RAM_ADDR_W_DEF = 3;

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once with a zero write,
// then parks in READY until the next reset.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  ram_state_t        state_r;
  ram_state_t        state_s;
  logic [ADDR_W-1:0] clr_addr_r;
  logic [ADDR_W-1:0] clr_addr_s;

  // State and sweep pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= CLEAR;
      clr_addr_r <= '0;
    end else begin
      state_r    <= state_s;
      clr_addr_r <= clr_addr_s;
    end
  end

  // Next-state logic: leave CLEAR on the edge that zeroes the last word.
  always_comb begin
    state_s    = state_r;
    clr_addr_s = clr_addr_r;
    case (state_r)
      CLEAR: begin
        clr_addr_s = clr_addr_r + ADDR_W'(1);
        if (clr_addr_r == LAST_ADDR) begin
          state_s = READY;
        end else begin
          state_s = CLEAR;
        end
      end
      READY: begin
        state_s    = READY;
        clr_addr_s = clr_addr_r;
      end
      default: begin
        state_s    = CLEAR;
        clr_addr_s = '0;
      end
    endcase
  end

  assign ready    = (state_r == READY);
  assign clr_we   = (state_r == CLEAR);
  assign clr_addr = clr_addr_r;

endmodule

// File: rtl/ram_bank.sv
// Parametrised RAM bank with hardware clear sweep after reset.
// Optional feature: define RAM_BANK_OUTREG_EN for a registered, read-first output.
module ram_bank
  import ram_pkg::*;
#(
  parameter int WIDTH  = RAM_WIDTH_DEF,
  parameter int ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic              ready_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [WIDTH-1:0]  wdata_s;
  logic [WIDTH-1:0]  rdata_s;

  ram_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Write port mux: the sweep owns the port until ready, user input is ignored meanwhile.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = address;
    wdata_s = in;
    if (clr_we_s) begin
      we_s    = 1'b1;
      waddr_s = clr_addr_s;
      wdata_s = '0;
    end else if (ready_s) begin
      we_s    = load;
      waddr_s = address;
      wdata_s = in;
    end else begin
      we_s    = 1'b0;
    end
  end

  // Storage array; contents are not reset, only the sweep clears them.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  assign rdata_s = mem_r[address];

`ifdef RAM_BANK_OUTREG_EN
  logic [WIDTH-1:0] out_r;

  // Registered read: samples pre-write contents, held at zero until ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= '0;
    end else if (ready_s) begin
      out_r <= rdata_s;
    end else begin
      out_r <= '0;
    end
  end

  assign out = out_r;
`else
  // Combinational read, forced to zero while the sweep runs.
  always_comb begin
    if (ready_s) begin
      out = rdata_s;
    end else begin
      out = '0;
    end
  end
`endif

  assign ready = ready_s;

endmodule

// File: tb/tb_ram_bank.sv
// Randomised self-checking bench for ram_bank against an array-based reference model.
module tb_ram_bank;

  localparam int W      = 16;
  localparam int AW     = 3;
  localparam int DEPTH  = 8;
  localparam int BW     = 8;
  localparam int BAW    = 6;
`ifdef RAM_BANK_OUTREG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in;
  logic           load;
  logic [AW-1:0]  address;
  logic [W-1:0]   out;
  logic           ready;
  logic [BW-1:0]  in_b;
  logic           load_b;
  logic [BAW-1:0] address_b;
  logic [BW-1:0]  out_b;
  logic           ready_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory contents, edges of sweep seen, expected output register.
  logic [W-1:0] model [DEPTH];
  int           clr_cnt;
  logic [W-1:0] out_reg_exp;

  ram_bank #(.WIDTH(W), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load),
    .address(address), .out(out), .ready(ready)
  );

  ram_bank #(.WIDTH(BW), .ADDR_W(BAW)) u_big (
    .clk(clk), .rst_n(rst_n), .in(in_b), .load(load_b),
    .address(address_b), .out(out_b), .ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_out();
    if (OUTREG) return out_reg_exp;
    return (rst_n && clr_cnt >= DEPTH) ? model[address] : '0;
  endfunction

  // One clock edge: advance the model from its pre-edge view, then check both outputs.
  task automatic tick();
    bit           pre_ready;
    logic [W-1:0] pre_read;
    pre_ready = rst_n && (clr_cnt >= DEPTH);
    pre_read  = model[address];
    @(posedge clk);
    if (!rst_n) begin
      clr_cnt     = 0;
      out_reg_exp = '0;
    end else if (pre_ready) begin
      out_reg_exp = pre_read;
      if (load) model[address] = in;
    end else begin
      out_reg_exp     = '0;
      model[clr_cnt]  = '0;
      clr_cnt++;
    end
    #1;
    check("ready", {31'd0, ready}, {31'd0, (rst_n && clr_cnt >= DEPTH)});
    check("out", {16'd0, out}, {16'd0, exp_out()});
  endtask

  task automatic apply_reset();
    #2;
    rst_n       = 1'b0;
    clr_cnt     = 0;
    out_reg_exp = '0;
    #1;
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_out_b", {24'd0, out_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts edges from release until ready rises; bounded so a stuck FSM still ends.
  task automatic measure_ready(input string tag, input int expect_edges);
    int seen;
    seen = 0;
    for (int k = 1; k <= DEPTH + 4; k++) begin
      tick();
      if (ready === 1'b1 && seen == 0) seen = k;
    end
    check(tag, seen, expect_edges);
  endtask

  initial begin
    int es;
    int eb;
    rst_n = 1'b0; load = 1'b0; in = '0; address = '0;
    load_b = 1'b0; in_b = '0; address_b = '0;
    clr_cnt = 0; out_reg_exp = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    check("init_out", {16'd0, out}, 32'd0);
    check("init_ready", {31'd0, ready}, 32'd0);
    check("init_ready_b", {31'd0, ready_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear latency of both sizes, measured on the same run.
    es = 0; eb = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (ready === 1'b1 && es == 0) es = k;
      if (ready_b === 1'b1 && eb == 0) eb = k;
    end
    check("ready_lat", es, DEPTH);
    check("big_ready_lat", eb, 64);

    // Wide-address instance: extremes must not alias.
    load_b = 1'b1; in_b = 8'hFF; address_b = 6'd63; tick();
    in_b = 8'h01; address_b = 6'd0; tick();
    load_b = 1'b0; address_b = 6'd63; tick();
    check("big_rd63", {24'd0, out_b}, 32'h0000_00FF);
    address_b = 6'd0; tick();
    check("big_rd0", {24'd0, out_b}, 32'h0000_0001);
    address_b = 6'd1; tick();
    check("big_rd1", {24'd0, out_b}, 32'h0000_0000);

    // Garbage fill, then reset must sweep everything back to zero.
    for (int a = 0; a < DEPTH; a++) begin
      load = 1'b1; address = AW'(a); in = W'($urandom | 1); tick();
    end
    load = 1'b0;
    apply_reset();
    measure_ready("clear_lat", DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a); tick();
      check("clear_read", {16'd0, out}, 32'd0);
    end

    // Write 1..8 to 0..7, then read back.
    load = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a); in = W'(a + 1); tick();
    end
    load = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a); tick();
      check("sweep_read", {16'd0, out}, a + 1);
    end

    // Same-address write and read: old value first, new value after.
    load = 1'b1; address = 3'd5; in = 16'h0011; tick();
    in = 16'h0022; #1;
    check("rw_before", {16'd0, out}, OUTREG ? 32'h0000_0006 : 32'h0000_0011);
    tick();
    check("rw_after", {16'd0, out}, OUTREG ? 32'h0000_0011 : 32'h0000_0022);
    load = 1'b0; tick();
    check("rw_later", {16'd0, out}, 32'h0000_0022);

    // Writes held during the whole sweep, including the transition edge, are dropped.
    load = 1'b1; in = 16'hBEEF; address = 3'd3;
    apply_reset();
    for (int k = 0; k < DEPTH; k++) tick();
    load = 1'b0;
    tick();
    check("clr_wr_ignored", {16'd0, out}, 32'd0);

    // Reset mid-sweep restarts the sweep from address 0.
    apply_reset();
    for (int k = 0; k < 3; k++) tick();
    apply_reset();
    measure_ready("midsweep_lat", DEPTH);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      load    = 1'($urandom_range(0, 1));
      address = AW'($urandom_range(0, DEPTH - 1));
      in      = W'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
